// File: rtl/puzzle_pkg.sv
// Shared definitions for the sliding-puzzle board engine.
//   - direction encodings used by user buttons and by the scrambler LFSR
//   - bit positions of the conditioned button pulse vector
//   - top-level state enum
//   - constant ceil(log2) helper and the LFSR feedback tap mask
package puzzle_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int BTN_UP       = 0;
    localparam int BTN_DOWN     = 1;
    localparam int BTN_LEFT     = 2;
    localparam int BTN_RIGHT    = 3;
    localparam int BTN_SCRAMBLE = 4;

    // Taps 16,14,13,11 of the 16-bit Fibonacci LFSR, as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE,
        SCRAMBLE
    } state_e;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD up-counter.
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset (count -> 0)
//   inc    in  add one unless already all nines
//   clr    in  clear to zero (wins over inc)
//   bcd    out count, digit 0 in [3:0]
module bcd_counter
    import puzzle_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                clr,
    output logic [4*DIGITS-1:0] bcd
);

    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_d;
    logic                carry;
    logic                all_nines;

    // Ripple a decimal carry from digit 0 upward; once every digit is 9 the
    // count holds instead of wrapping.
    always_comb begin
        bcd_d     = bcd_q;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
        end
        if (clr) begin
            bcd_d = '0;
        end else if (inc && !all_nines) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (bcd_q[4*i +: 4] == 4'd9) begin
                        bcd_d[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/sliding_puzzle_core.sv
// N-puzzle board engine: holds the tile array, moves the blank on button
// pulses, counts legal moves in BCD, flags the solved layout and can
// self-scramble with LFSR-chosen moves.
//   clk        in  system clock
//   rst_n      in  synchronous active-low reset
//   btn        in  one-cycle pulses [0]up [1]down [2]left [3]right [4]scramble
//   rd_addr    in  cell index (row*SIDE+col) for display readout
//   rd_tile    out tile at rd_addr (0 = blank, 0 for indices past the board)
//   blank_pos  out current blank cell index
//   move_bcd   out legal user move count, BCD
//   solved     out board equals solved layout (one cycle behind the board)
//   busy       out high while scrambling
//   illegal    out one-cycle pulse when a user move hits the board edge
module sliding_puzzle_core
    import puzzle_pkg::*;
#(
    parameter  int          SIDE           = 3,
    parameter  int          CNT_DIGITS     = 4,
    parameter  int          SCRAMBLE_MOVES = 64,
    parameter  logic [15:0] LFSR_SEED      = 16'hACE1,
    localparam int          CELLS          = SIDE * SIDE,
    localparam int          AW             = clog2(CELLS),
    localparam int          TW             = AW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            btn,
    input  logic [AW-1:0]         rd_addr,
    output logic [TW-1:0]         rd_tile,
    output logic [AW-1:0]         blank_pos,
    output logic [4*CNT_DIGITS-1:0] move_bcd,
    output logic                  solved,
    output logic                  busy,
    output logic                  illegal
);

    localparam int RW = clog2(SIDE);
    localparam int SW = clog2(SCRAMBLE_MOVES + 1);
    localparam logic [RW-1:0] LAST_RC = RW'(SIDE - 1);

    state_e              state_q,     state_d;
    logic [TW*CELLS-1:0] board_q,     board_d;
    logic [AW-1:0]       blank_pos_q, blank_pos_d;
    logic [RW-1:0]       blank_row_q, blank_row_d;
    logic [RW-1:0]       blank_col_q, blank_col_d;
    logic [15:0]         lfsr_q,      lfsr_d;
    logic [SW-1:0]       scr_cnt_q,   scr_cnt_d;
    logic                illegal_q,   illegal_d;
    logic                solved_q,    solved_d;

    logic [TW*CELLS-1:0] solved_board;
    logic                move_req;
    logic [1:0]          dir;
    logic                legal;
    logic [AW-1:0]       nb_pos;
    logic [RW-1:0]       nb_row;
    logic [RW-1:0]       nb_col;
    logic [TW-1:0]       nb_tile;
    logic                cnt_inc;
    logic                cnt_clr;

    // Solved layout: tiles 1..CELLS-1 in order with the blank in the last cell.
    always_comb begin
        solved_board = '0;
        for (int i = 0; i < CELLS - 1; i++) begin
            solved_board[i*TW +: TW] = TW'(i + 1);
        end
    end

    // Display readout mux; indices beyond the board read as blank.
    always_comb begin
        rd_tile = '0;
        for (int i = 0; i < CELLS; i++) begin
            if (AW'(i) == rd_addr) begin
                rd_tile = board_q[i*TW +: TW];
            end
        end
    end

    // Next-state logic. Pick one action per cycle (scramble first, then
    // up > down > left > right), check it against the tracked blank row/col
    // so no divider is needed, then swap the blank with its neighbour.
    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        blank_pos_d = blank_pos_q;
        blank_row_d = blank_row_q;
        blank_col_d = blank_col_q;
        lfsr_d      = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        scr_cnt_d   = scr_cnt_q;
        illegal_d   = 1'b0;
        solved_d    = (board_q == solved_board);
        move_req    = 1'b0;
        dir         = DIR_UP;
        legal       = 1'b0;
        nb_pos      = blank_pos_q;
        nb_row      = blank_row_q;
        nb_col      = blank_col_q;
        nb_tile     = '0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn[BTN_SCRAMBLE]) begin
                    state_d   = SCRAMBLE;
                    scr_cnt_d = '0;
                end else if (btn[BTN_UP]) begin
                    move_req = 1'b1;
                    dir      = DIR_UP;
                end else if (btn[BTN_DOWN]) begin
                    move_req = 1'b1;
                    dir      = DIR_DOWN;
                end else if (btn[BTN_LEFT]) begin
                    move_req = 1'b1;
                    dir      = DIR_LEFT;
                end else if (btn[BTN_RIGHT]) begin
                    move_req = 1'b1;
                    dir      = DIR_RIGHT;
                end
            end
            SCRAMBLE: begin
                move_req = 1'b1;
                dir      = lfsr_q[1:0];
            end
            default: state_d = IDLE;
        endcase

        case (dir)
            DIR_UP: begin
                legal  = (blank_row_q != '0);
                nb_pos = blank_pos_q - AW'(SIDE);
                nb_row = blank_row_q - RW'(1);
            end
            DIR_DOWN: begin
                legal  = (blank_row_q != LAST_RC);
                nb_pos = blank_pos_q + AW'(SIDE);
                nb_row = blank_row_q + RW'(1);
            end
            DIR_LEFT: begin
                legal  = (blank_col_q != '0);
                nb_pos = blank_pos_q - AW'(1);
                nb_col = blank_col_q - RW'(1);
            end
            default: begin
                legal  = (blank_col_q != LAST_RC);
                nb_pos = blank_pos_q + AW'(1);
                nb_col = blank_col_q + RW'(1);
            end
        endcase

        for (int i = 0; i < CELLS; i++) begin
            if (AW'(i) == nb_pos) begin
                nb_tile = board_q[i*TW +: TW];
            end
        end

        if (move_req && legal) begin
            for (int i = 0; i < CELLS; i++) begin
                if (AW'(i) == blank_pos_q) begin
                    board_d[i*TW +: TW] = nb_tile;
                end
                if (AW'(i) == nb_pos) begin
                    board_d[i*TW +: TW] = '0;
                end
            end
            blank_pos_d = nb_pos;
            blank_row_d = nb_row;
            blank_col_d = nb_col;
            if (state_q == IDLE) begin
                cnt_inc = 1'b1;
            end else begin
                scr_cnt_d = scr_cnt_q + SW'(1);
                if (scr_cnt_q == SW'(SCRAMBLE_MOVES - 1)) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            end
        end else if (move_req && (state_q == IDLE)) begin
            // Only user moves report a blocked edge; scrambler misses are silent.
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            board_q     <= solved_board;
            blank_pos_q <= AW'(CELLS - 1);
            blank_row_q <= LAST_RC;
            blank_col_q <= LAST_RC;
            lfsr_q      <= LFSR_SEED;
            scr_cnt_q   <= '0;
            illegal_q   <= 1'b0;
            solved_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            blank_pos_q <= blank_pos_d;
            blank_row_q <= blank_row_d;
            blank_col_q <= blank_col_d;
            lfsr_q      <= lfsr_d;
            scr_cnt_q   <= scr_cnt_d;
            illegal_q   <= illegal_d;
            solved_q    <= solved_d;
        end
    end

    bcd_counter #(
        .DIGITS(CNT_DIGITS)
    ) u_move_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .bcd  (move_bcd)
    );

    assign blank_pos = blank_pos_q;
    assign solved    = solved_q;
    assign busy      = (state_q == SCRAMBLE);
    assign illegal   = illegal_q;

endmodule
